// File: rtl/fp_recip_scaler.sv
// Scales an FP32 element stream by the reciprocal of one divisor fetched from an external floatRec unit.
// Optional macro FP_RECIP_SCALER_RNE_EN selects round-to-nearest-even instead of truncation.
module fp_recip_scaler #(
   parameter int DATA_WIDTH = 32,
   parameter int RECIP_LAT  = 4,
   parameter int LEN_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] cfg_div,
   input  logic [LEN_W-1:0]      cfg_len,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] recip_x,
   input  logic [DATA_WIDTH-1:0] recip_y,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
);

   localparam int WAIT_W = $clog2(RECIP_LAT + 1);
`ifdef FP_RECIP_SCALER_RNE_EN
   localparam int PL = 0;
`else
   localparam int PL = 23;
`endif

   typedef enum logic [1:0] {IDLE, WAIT_RECIP, SCALE, DONE} state_t;

   state_t                state;
   logic [LEN_W-1:0]      len;
   logic [LEN_W-1:0]      acc_cnt;
   logic [LEN_W-1:0]      emt_cnt;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [DATA_WIDTH-1:0] recip;
   logic                  vld_p1;
   logic                  vld_p2;
   logic                  stall;
   logic                  in_fire;
   logic                  out_fire;

   // stage-1 combinational operands and registered results
   logic [7:0]         ea, eb;
   logic [22:0]        fa, fb;
   logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic               sign_c, nan_c, inf_c, zero_c;
   logic signed [9:0]  esum_c;
   logic [47:0]        prod_c;
   logic               sign_p1, nan_p1, inf_p1, zero_p1;
   logic signed [9:0]  exp_p1;
   logic [47:PL]       prod_p1;

   logic [22:0]        m_n, m_r;
   logic signed [9:0]  e_n, e_r;
   logic [31:0]        res_c;
`ifdef FP_RECIP_SCALER_RNE_EN
   logic               g_n, st_n;
`else
   logic               unused_prod_lsbs;
   assign unused_prod_lsbs = ^prod_c[22:0];
`endif

   // Exponent overflow saturates to signed inf, underflow flushes to signed zero.
   function automatic logic [31:0] pack_sat(input logic s, input logic signed [9:0] e,
                                            input logic [22:0] m);
      if (e >= 10'sd255)
         pack_sat = {s, 8'hFF, 23'd0};
      else if (e <= 10'sd0)
         pack_sat = {s, 31'd0};
      else
         pack_sat = {s, e[7:0], m};
   endfunction

`ifdef FP_RECIP_SCALER_RNE_EN
   // Returns {exponent, mantissa}; a mantissa carry-out bumps the exponent.
   function automatic logic [32:0] round_rne(input logic signed [9:0] e, input logic [22:0] m,
                                             input logic g, input logic st);
      logic [23:0]       sum;
      logic signed [9:0] en;
      sum = {1'b0, m} + {23'd0, (g && (st || m[0]))};
      en  = sum[23] ? e + 10'sd1 : e;
      round_rne = {en, sum[22:0]};
   endfunction
`endif

   assign stall    = vld_p2 && !out_ready;
   assign in_ready = (state == SCALE) && (acc_cnt < len) && !stall;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = vld_p2 && out_ready;
   assign out_valid = vld_p2;

   always_comb begin
      ea     = in_data[30:23];
      fa     = in_data[22:0];
      eb     = recip[30:23];
      fb     = recip[22:0];
      a_zero = (ea == 8'd0);
      b_zero = (eb == 8'd0);
      a_inf  = (ea == 8'hFF) && (fa == 23'd0);
      b_inf  = (eb == 8'hFF) && (fb == 23'd0);
      a_nan  = (ea == 8'hFF) && (fa != 23'd0);
      b_nan  = (eb == 8'hFF) && (fb != 23'd0);
      sign_c = in_data[31] ^ recip[31];
      nan_c  = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
      inf_c  = (a_inf || b_inf) && !nan_c;
      zero_c = (a_zero || b_zero) && !nan_c;
      esum_c = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
      prod_c = 48'({1'b1, fa}) * 48'({1'b1, fb});
   end

   // ---- stage 1 -> stage 2 boundary ----
   always_comb begin
      if (prod_p1[47]) begin
         m_n = prod_p1[46:24];
         e_n = exp_p1 + 10'sd1;
      end else begin
         m_n = prod_p1[45:23];
         e_n = exp_p1;
      end
`ifdef FP_RECIP_SCALER_RNE_EN
      if (prod_p1[47]) begin
         g_n  = prod_p1[23];
         st_n = |prod_p1[22:0];
      end else begin
         g_n  = prod_p1[22];
         st_n = |prod_p1[21:0];
      end
      {e_r, m_r} = round_rne(e_n, m_n, g_n, st_n);
`else
      e_r = e_n;
      m_r = m_n;
`endif
      res_c = pack_sat(sign_p1, e_r, m_r);
      if (nan_p1)
         res_c = 32'h7FC00000;
      else if (inf_p1)
         res_c = {sign_p1, 8'hFF, 23'd0};
      else if (zero_p1)
         res_c = {sign_p1, 31'd0};
   end

   always_ff @(posedge clk) begin
      if (state == WAIT_RECIP && wait_cnt == WAIT_W'(RECIP_LAT))
         recip <= recip_y;
      if (!stall) begin
         sign_p1 <= sign_c;
         nan_p1  <= nan_c;
         inf_p1  <= inf_c;
         zero_p1 <= zero_c;
         exp_p1  <= esum_c;
         prod_p1 <= prod_c[47:PL];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         recip_x  <= '0;
         len      <= '0;
         acc_cnt  <= '0;
         emt_cnt  <= '0;
         wait_cnt <= '0;
         vld_p1   <= 1'b0;
         vld_p2   <= 1'b0;
         out_data <= '0;
      end else begin
         done <= 1'b0;
         // ---- stage 2 output register ----
         if (!stall) begin
            vld_p1 <= in_fire;
            vld_p2 <= vld_p1;
            if (vld_p1)
               out_data <= res_c;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (cfg_len != '0) begin
                     recip_x  <= cfg_div;
                     len      <= cfg_len;
                     wait_cnt <= '0;
                     acc_cnt  <= '0;
                     emt_cnt  <= '0;
                     state    <= WAIT_RECIP;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            WAIT_RECIP: begin
               if (wait_cnt == WAIT_W'(RECIP_LAT))
                  state <= SCALE;
               else
                  wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            SCALE: begin
               if (in_fire)
                  acc_cnt <= acc_cnt + LEN_W'(1);
               if (out_fire) begin
                  emt_cnt <= emt_cnt + LEN_W'(1);
                  if (emt_cnt == len - LEN_W'(1)) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fp_recip_scaler.md
Name: fp_recip_scaler

Overview:
- Divides a stream of FP32 elements by one FP32 divisor, computed as multiplication by the divisor's reciprocal.
- Sits directly downstream of the pipelined floatRec reciprocal unit.
- Drives the divisor into floatRec, waits its fixed latency and latches the reciprocal.
- Streams cfg_len elements through a 2-stage FP32 multiplier with valid/ready handshakes. Typical use: softmax / layer normalisation in the CNN datapath.

Parameters:
- DATA_WIDTH, 32: element width; only IEEE-754 single precision (32) is supported.
- RECIP_LAT, 4: cycles from recip_x change to a valid recip_y; must match the floatRec instance.
- LEN_W, 16: width of the element-count field.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; ignored unless state is IDLE.
- cfg_div  in  DATA_WIDTH  divisor, sampled on an accepted start.
- cfg_len  in  LEN_W  number of elements, sampled on an accepted start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last output handshake.
- recip_x  out  DATA_WIDTH  to floatRec X; holds the latched divisor.
- recip_y  in  DATA_WIDTH  from floatRec Y.
- in_valid  in  1  element valid.
- in_ready  out  1  element accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  element.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_WIDTH  element × reciprocal.

Behaviour:
- Reset (async, any time, including mid-job): state IDLE; all of the following are 0: busy, done, in_ready, out_valid, out_data, recip_x, counters, pipeline valids. Any in-flight job is lost.
- FSM states: IDLE, WAIT_RECIP, SCALE, DONE.
  - IDLE: on start with cfg_len != 0, latch cfg_div into recip_x, latch cfg_len, clear the wait counter, go to WAIT_RECIP.
  - IDLE: on start with cfg_len == 0, go to DONE; no reciprocal request is made.
  - WAIT_RECIP: count RECIP_LAT cycles. In the cycle the count reaches RECIP_LAT, latch recip_y into the internal recip register and go to SCALE.
  - SCALE: accept inputs until cfg_len elements have been accepted. When cfg_len outputs have handshaken, go to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE. A start arriving in the DONE cycle is ignored.
- Pipeline: 2 stages, stall-all.
  - Stage 1: unpack, sign XOR, exponent sum, 24×24 mantissa product.
  - Stage 2: normalise, round, handle special cases, register out_data.
  - Latency is 2 cycles from input handshake to out_valid when not stalled.
  - Stall condition: out_valid && !out_ready. While stalled, no stage advances and out_data/out_valid hold stable.
- in_ready = (state == SCALE) && (accepted < len) && !stall.
- Back-to-back throughput: 1 element per cycle.
- Arithmetic rules:
  - Denormal inputs (element or reciprocal) are treated as signed zero.
  - Any NaN operand, or inf × 0, gives 0x7FC00000.
  - inf × finite nonzero gives signed inf.
  - Zero × finite gives signed zero (sign = XOR of operand signs).
  - Biased exponent after rounding ≥ 255 gives signed inf (0x7F800000 | sign).
  - Biased exponent ≤ 0 gives signed zero (flush to zero, no denormal outputs).
  - Default rounding is truncation (round toward zero).
- Counters: accepted/emitted counters are LEN_W bits; cfg_len = 2^LEN_W − 1 must complete without wrap.

Optional Feature:
- Macro: FP_RECIP_SCALER_RNE_EN.
- Defined: stage 2 uses round-to-nearest-even via guard and sticky bits. A mantissa carry-out renormalises and increments the exponent, and overflow is then rechecked.
- Undefined: truncation; guard/sticky logic is not synthesised.
- Latency is 2 cycles in both builds.

Test Plan:
- Basic stream: bench floatRec stub returns 0x3F000000 (recip of 2.0); start with div=0x40000000, len=3; inputs 0x40400000, 0x3F800000, 0xC1000000 -> outputs 0x3FC00000, 0x3F000000, 0xC0800000 in order; done pulses once; busy falls the next cycle.
- Specials: recip 0x40800000; inputs 0x7F000000, 0x7FC00001, 0x00000001, 0x80000000 -> outputs 0x7F800000, 0x7FC00000, 0x00000000, 0x80000000. Then recip 0x3F000000 with input 0x00800000 -> 0x00000000 (underflow flush).
- Rounding: recip 0x3F800001, input 0x40400000 -> 0x40400001 without the macro; 0x40400002 with FP_RECIP_SCALER_RNE_EN.
- Backpressure: len=4, out_ready held 0 for 5 cycles after the first out_valid -> out_data stable, in_ready = 0 while stalled, no loss or duplication; all 4 results follow in order once out_ready = 1.
- Control edges: start with len=0 -> done exactly 1 cycle after start, recip_x unchanged. A start asserted during SCALE is ignored. recip_y sampled exactly RECIP_LAT cycles after start (stub output changes one cycle later must not affect results).
- Reset mid-operation: rst_n low during SCALE with 2 of 4 elements emitted -> all outputs 0 immediately; after release, a new job len=1 completes correctly.
